// File: rtl/spi_slave_stream.sv
// -----------------------------------------------------------------------------
// spi_slave_stream
//
// SPI slave for the synth control path. The SPI pins are oversampled in the
// system clock domain, deserialised into WORD_W-bit words (any SPI mode,
// MSB- or LSB-first) and buffered in a first-word-fall-through FIFO with a
// valid/ready output stream. A reply word is shifted out on MISO at the same
// time.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   sclk       SPI clock from the master (asynchronous)
//   csel       chip select, active low (asynchronous)
//   mosi       master-out data (asynchronous)
//   miso       slave-out data, 0 while not selected
//   tx_data    reply word, latched at frame start and at every word boundary
//   m_data     head-of-FIFO word (0 while empty)
//   m_valid    FIFO non-empty
//   m_ready    consumer accepts the head word when m_valid && m_ready
//   level      current FIFO occupancy
//   overflow   sticky: a received word was dropped because the FIFO was full
//   frame_err  one-cycle pulse: csel deasserted in the middle of a word
//   clr_flags  clears overflow
// -----------------------------------------------------------------------------
module spi_slave_stream #(
  parameter int WORD_W    = 8,
  parameter int DEPTH     = 4,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sclk,
  input  logic                     csel,
  input  logic                     mosi,
  output logic                     miso,
  input  logic [WORD_W-1:0]        tx_data,
  output logic [WORD_W-1:0]        m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     frame_err,
  input  logic                     clr_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WORD_W + 1);

  localparam logic [CW-1:0] BIT_LAST = CW'(WORD_W - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  logic       sclk_s1, sclk_s2, sclk_s3;
  logic       csel_s1, csel_s2, csel_s3;
  logic       mosi_s1, mosi_s2;
  logic [1:0] settle;
  logic       armed;

  // NOTE: every register here is updated with <= so all of them see the
  // values from before the clock edge; with = the synchroniser chain would
  // collapse into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1 <= CPOL;
      sclk_s2 <= CPOL;
      sclk_s3 <= CPOL;
      csel_s1 <= 1'b1;
      csel_s2 <= 1'b1;
      csel_s3 <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      settle  <= 2'b00;
      armed   <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      csel_s1 <= csel;
      csel_s2 <= csel_s1;
      csel_s3 <= csel_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      settle  <= {settle[0], 1'b1};
      // Reset preloads csel as idle-high. If the master still holds csel low
      // when reset ends, that preload would look like a fresh falling edge.
      // Only accept a frame start once the real pin has been seen high after
      // the synchroniser has flushed its reset value.
      if (settle[1] && csel_s2) armed <= 1'b1;
    end
  end

  logic sclk_edge, lead_edge, trail_edge;
  logic sample_edge, shift_edge;
  logic csel_fall, csel_rise;

  assign sclk_edge   = sclk_s2 ^ sclk_s3;
  assign lead_edge   = sclk_edge && (sclk_s3 == CPOL);
  assign trail_edge  = sclk_edge && (sclk_s3 != CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;
  assign csel_fall   = armed && csel_s3 && !csel_s2;
  assign csel_rise   = !csel_s3 && csel_s2;

  // ---------------------------------------------------------------------------
  // Frame FSM, deserialiser and reply shifter
  // ---------------------------------------------------------------------------
  logic [0:0]        state;
  logic [CW-1:0]     bit_cnt;
  logic [WORD_W-1:0] rx_shift;
  logic [WORD_W-1:0] rx_next;
  logic [WORD_W-1:0] tx_shift;
  logic [WORD_W-1:0] tx_adv;
  logic              tx_first;
  logic              skip_shift;
  logic              push_req;
  logic [WORD_W-1:0] push_data;

  generate
    if (LSB_FIRST) begin : g_lsb
      assign rx_next  = {mosi_s2, rx_shift[WORD_W-1:1]};
      assign tx_adv   = {1'b0, tx_shift[WORD_W-1:1]};
      assign tx_first = tx_shift[0];
    end else begin : g_msb
      assign rx_next  = {rx_shift[WORD_W-2:0], mosi_s2};
      assign tx_adv   = {tx_shift[WORD_W-2:0], 1'b0};
      assign tx_first = tx_shift[WORD_W-1];
    end
  endgenerate

  assign miso = (state == ST_SHIFT) ? tx_first : 1'b0;

  // skip_shift suppresses one shift edge after the reply register is loaded,
  // so the freshly loaded first bit is presented rather than shifted away:
  // at frame start for CPHA=1 (first leading edge only presents the bit) and
  // after every word boundary in both phases (the reload already lines up the
  // next word's first bit).
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      skip_shift <= 1'b0;
      push_req   <= 1'b0;
      push_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      push_req  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (csel_fall) begin
            state      <= ST_SHIFT;
            bit_cnt    <= '0;
            tx_shift   <= tx_data;
            skip_shift <= CPHA;
          end
        end
        ST_SHIFT: begin
          if (csel_rise) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            if (bit_cnt != '0) frame_err <= 1'b1;
          end else if (sample_edge) begin
            rx_shift <= rx_next;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt    <= '0;
              push_req   <= 1'b1;
              push_data  <= rx_next;
              tx_shift   <= tx_data;
              skip_shift <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else if (shift_edge) begin
            if (skip_shift) skip_shift <= 1'b0;
            else            tx_shift   <= tx_adv;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, pop, wr_en, drop;

  assign full    = (count == FIFO_FULL);
  assign m_valid = (count != '0);
  assign pop     = m_valid && m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en   = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;
  assign level   = count;
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

  // NOTE: the storage array has no reset; m_data is masked while empty and
  // occupancy lives in the reset pointers, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      // A new drop wins over a simultaneous clear.
      if (drop)           overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_slave_stream.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_stream
//
// Directed bench for spi_slave_stream. Three instances cover the modes under
// test:
//   u0: WORD_W=8, mode 0, MSB-first (main instance)
//   u1: WORD_W=4, mode 0, LSB-first
//   u2: WORD_W=8, CPOL=1, CPHA=1, MSB-first
// A behavioural SPI master drives each instance, sclk half period = 6 clk.
// -----------------------------------------------------------------------------
module tb_spi_slave_stream;

  localparam int HALF = 6;

  logic       clk;
  logic       rst;
  logic [2:0] sclk;
  logic [2:0] csel;
  logic [2:0] mosi;

  logic       miso0, miso1, miso2;
  logic [7:0] tx_data0, m_data0;
  logic       m_valid0, m_ready0, overflow0, frame_err0, clr0;
  logic [2:0] level0;
  logic [3:0] tx_data1, m_data1;
  logic       m_valid1, m_ready1, overflow1, frame_err1, clr1;
  logic [2:0] level1;
  logic [7:0] tx_data2, m_data2;
  logic       m_valid2, m_ready2, overflow2, frame_err2, clr2;
  logic [2:0] level2;

  int checks   = 0;
  int failures = 0;

  spi_slave_stream #(.WORD_W(8), .DEPTH(4), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .sclk(sclk[0]), .csel(csel[0]), .mosi(mosi[0]), .miso(miso0),
    .tx_data(tx_data0), .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready0),
    .level(level0), .overflow(overflow0), .frame_err(frame_err0), .clr_flags(clr0));

  spi_slave_stream #(.WORD_W(4), .DEPTH(4), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .sclk(sclk[1]), .csel(csel[1]), .mosi(mosi[1]), .miso(miso1),
    .tx_data(tx_data1), .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1),
    .level(level1), .overflow(overflow1), .frame_err(frame_err1), .clr_flags(clr1));

  spi_slave_stream #(.WORD_W(8), .DEPTH(4), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst(rst), .sclk(sclk[2]), .csel(csel[2]), .mosi(mosi[2]), .miso(miso2),
    .tx_data(tx_data2), .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready2),
    .level(level2), .overflow(overflow2), .frame_err(frame_err2), .clr_flags(clr2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count clk cycles during which frame_err0 is high (pulse width check).
  int fe_cnt0 = 0;
  always @(posedge clk) if (frame_err0) fe_cnt0 <= fe_cnt0 + 1;

  // Time of the last leading sclk edge on u0, and of m_valid0 rising.
  time lead_t = 0;
  time mv_rise_t = 0;
  always @(posedge m_valid0) mv_rise_t = $time;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic get_miso(input int k);
    case (k)
      0:       return miso0;
      1:       return miso1;
      default: return miso2;
    endcase
  endfunction

  task automatic frame_begin(input int k);
    csel[k] = 1'b0;
    wait_clk(8);
  endtask

  task automatic frame_end(input int k);
    wait_clk(HALF);
    csel[k] = 1'b1;
    wait_clk(8);
  endtask

  // Transfers nbits of data (word-relative bit order) and returns what the
  // master captured on MISO in the same bit positions.
  task automatic spi_bits(input int k, input logic [31:0] data, input int nbits,
                          output logic [31:0] rx);
    logic cpol, cpha, lsb;
    int   nw, idx;
    cpol = (k == 2);
    cpha = (k == 2);
    lsb  = (k == 1);
    nw   = (k == 1) ? 4 : 8;
    rx   = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = lsb ? i : nw - 1 - i;
      if (!cpha) begin
        mosi[k] = data[idx];
        wait_clk(HALF);
        sclk[k] = ~cpol;
        if (k == 0) lead_t = $time;
        rx[idx] = get_miso(k);
        wait_clk(HALF);
        sclk[k] = cpol;
      end else begin
        sclk[k] = ~cpol;
        mosi[k] = data[idx];
        wait_clk(HALF);
        sclk[k] = cpol;
        rx[idx] = get_miso(k);
        wait_clk(HALF);
      end
    end
  endtask

  task automatic pop0();
    m_ready0 = 1'b1;
    wait_clk(1);
    m_ready0 = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (m_valid0 !== 1'b0)  begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid0); end
    checks++; if (m_data0 !== 8'h00)  begin failures++; $display("FAIL reset_m_data got=%h exp=00", m_data0); end
    checks++; if (level0 !== 3'd0)    begin failures++; $display("FAIL reset_level got=%0d exp=0", level0); end
    checks++; if (overflow0 !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow0); end
    checks++; if (frame_err0 !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err0); end
    checks++; if (miso0 !== 1'b0)     begin failures++; $display("FAIL reset_miso0 got=%b exp=0", miso0); end
    checks++; if (level1 !== 3'd0)    begin failures++; $display("FAIL reset_level1 got=%0d exp=0", level1); end
    checks++; if (miso2 !== 1'b0)     begin failures++; $display("FAIL reset_miso2 got=%b exp=0", miso2); end
  endtask

  task automatic test_mode0();
    logic [31:0] rx;
    tx_data0  = 8'h96;
    mv_rise_t = 0;
    frame_begin(0);
    spi_bits(0, 32'hA5, 8, rx);
    frame_end(0);
    checks++; if (rx[7:0] !== 8'h96)  begin failures++; $display("FAIL mode0_miso got=%h exp=96", rx[7:0]); end
    checks++; if (m_data0 !== 8'hA5)  begin failures++; $display("FAIL mode0_m_data got=%h exp=a5", m_data0); end
    checks++; if (m_valid0 !== 1'b1)  begin failures++; $display("FAIL mode0_m_valid got=%b exp=1", m_valid0); end
    checks++; if (level0 !== 3'd1)    begin failures++; $display("FAIL mode0_level got=%0d exp=1", level0); end
    checks++;
    if (mv_rise_t <= lead_t || mv_rise_t - lead_t > 40) begin
      failures++; $display("FAIL mode0_latency got=%0t exp=<=40 after last edge", mv_rise_t - lead_t);
    end
    pop0();
    checks++; if (level0 !== 3'd0)    begin failures++; $display("FAIL mode0_pop_level got=%0d exp=0", level0); end
  endtask

  task automatic test_lsb_first();
    logic [31:0] rx;
    tx_data1 = 4'hA;
    frame_begin(1);
    spi_bits(1, 32'h7, 4, rx);
    checks++; if (rx[3:0] !== 4'hA)  begin failures++; $display("FAIL lsb_miso_w0 got=%h exp=a", rx[3:0]); end
    checks++; if (m_data1 !== 4'h7)  begin failures++; $display("FAIL lsb_word0 got=%h exp=7", m_data1); end
    checks++; if (level1 !== 3'd1)   begin failures++; $display("FAIL lsb_level1 got=%0d exp=1", level1); end
    spi_bits(1, 32'h3, 4, rx);
    frame_end(1);
    checks++; if (rx[3:0] !== 4'hA)  begin failures++; $display("FAIL lsb_miso_w1 got=%h exp=a", rx[3:0]); end
    checks++; if (level1 !== 3'd2)   begin failures++; $display("FAIL lsb_level2 got=%0d exp=2", level1); end
    m_ready1 = 1'b1;
    wait_clk(1);
    m_ready1 = 1'b0;
    checks++; if (m_data1 !== 4'h3)  begin failures++; $display("FAIL lsb_word1 got=%h exp=3", m_data1); end
    checks++; if (level1 !== 3'd1)   begin failures++; $display("FAIL lsb_pop_level got=%0d exp=1", level1); end
  endtask

  task automatic test_overflow();
    logic [31:0] rx;
    logic [7:0]  words [5];
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    m_ready0 = 1'b0;
    tx_data0 = 8'h00;
    frame_begin(0);
    for (int i = 0; i < 5; i++) spi_bits(0, {24'h0, words[i]}, 8, rx);
    frame_end(0);
    checks++; if (level0 !== 3'd4)    begin failures++; $display("FAIL ovf_level got=%0d exp=4", level0); end
    checks++; if (overflow0 !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_data0 !== words[i]) begin
        failures++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, m_data0, words[i]);
      end
      pop0();
    end
    checks++; if (m_valid0 !== 1'b0)  begin failures++; $display("FAIL ovf_empty got=%b exp=0", m_valid0); end
    // Pop while empty must leave the FIFO alone.
    m_ready0 = 1'b1;
    wait_clk(2);
    m_ready0 = 1'b0;
    checks++; if (level0 !== 3'd0)    begin failures++; $display("FAIL pop_empty_level got=%0d exp=0", level0); end
    checks++; if (overflow0 !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow0); end
    clr0 = 1'b1;
    wait_clk(1);
    clr0 = 1'b0;
    checks++; if (overflow0 !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow0); end
  endtask

  task automatic test_frame_err();
    logic [31:0] rx;
    int          fe0;
    fe0 = fe_cnt0;
    frame_begin(0);
    spi_bits(0, 32'hFF, 3, rx);
    frame_end(0);
    checks++; if (fe_cnt0 - fe0 !== 1) begin failures++; $display("FAIL ferr_pulse_cycles got=%0d exp=1", fe_cnt0 - fe0); end
    checks++; if (level0 !== 3'd0)     begin failures++; $display("FAIL ferr_no_push got=%0d exp=0", level0); end
    frame_begin(0);
    spi_bits(0, 32'h5A, 8, rx);
    frame_end(0);
    checks++; if (m_data0 !== 8'h5A)   begin failures++; $display("FAIL ferr_next_data got=%h exp=5a", m_data0); end
    checks++; if (level0 !== 3'd1)     begin failures++; $display("FAIL ferr_next_level got=%0d exp=1", level0); end
    checks++; if (fe_cnt0 - fe0 !== 1) begin failures++; $display("FAIL ferr_clean_frame got=%0d exp=1", fe_cnt0 - fe0); end
    pop0();
  endtask

  task automatic test_mode3();
    logic [31:0] rx;
    tx_data2 = 8'h3C;
    frame_begin(2);
    spi_bits(2, 32'h00, 8, rx);
    frame_end(2);
    checks++; if (rx[7:0] !== 8'h3C)  begin failures++; $display("FAIL mode3_miso got=%h exp=3c", rx[7:0]); end
    checks++; if (m_data2 !== 8'h00)  begin failures++; $display("FAIL mode3_m_data got=%h exp=00", m_data2); end
    checks++; if (m_valid2 !== 1'b1)  begin failures++; $display("FAIL mode3_m_valid got=%b exp=1", m_valid2); end
    checks++; if (level2 !== 3'd1)    begin failures++; $display("FAIL mode3_level got=%0d exp=1", level2); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rx;
    int          fe0;
    fe0 = fe_cnt0;
    frame_begin(0);
    spi_bits(0, 32'hFF, 5, rx);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    // Master finishes the interrupted word; the slave must ignore it.
    spi_bits(0, 32'hFF, 3, rx);
    frame_end(0);
    checks++; if (level0 !== 3'd0)     begin failures++; $display("FAIL rstmid_ignored got=%0d exp=0", level0); end
    frame_begin(0);
    spi_bits(0, 32'hC3, 8, rx);
    frame_end(0);
    checks++; if (m_data0 !== 8'hC3)   begin failures++; $display("FAIL rstmid_data got=%h exp=c3", m_data0); end
    checks++; if (level0 !== 3'd1)     begin failures++; $display("FAIL rstmid_level got=%0d exp=1", level0); end
    checks++; if (overflow0 !== 1'b0)  begin failures++; $display("FAIL rstmid_overflow got=%b exp=0", overflow0); end
    checks++; if (fe_cnt0 - fe0 !== 0) begin failures++; $display("FAIL rstmid_frame_err got=%0d exp=0", fe_cnt0 - fe0); end
  endtask

  initial begin
    rst      = 1'b1;
    sclk     = 3'b100;   // u2 idles high (CPOL=1)
    csel     = 3'b111;
    mosi     = 3'b000;
    tx_data0 = 8'h00;
    tx_data1 = 4'h0;
    tx_data2 = 8'h00;
    m_ready0 = 1'b0;
    m_ready1 = 1'b0;
    m_ready2 = 1'b0;
    clr0     = 1'b0;
    clr1     = 1'b0;
    clr2     = 1'b0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(6);

    test_reset();
    test_mode0();
    test_lsb_first();
    test_overflow();
    test_frame_err();
    test_mode3();
    test_reset_midframe();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_stream.md
Name: spi_slave_stream

Overview:
- Parametrised SPI slave for the synth control path, the successor to the fixed 4-bit LED receiver in `top`.
- Oversamples `ck_sck`, `ck_ss` and `ck_mosi` in the 100 MHz system domain and deserialises WORD_W-bit words in any SPI mode, MSB- or LSB-first.
- Buffers received words in a DEPTH-entry FIFO with a valid/ready output stream for the register/voice decoder.
- Simultaneously shifts a caller-supplied reply word out on MISO.

Parameters:
- WORD_W, 8, bits per SPI word (2..32)
- DEPTH, 4, receive FIFO entries (power of 2, ≥2)
- CPOL, 0, idle level of sclk
- CPHA, 0, 0 = sample on leading edge / shift on trailing edge; 1 = shift on leading edge / sample on trailing edge
- LSB_FIRST, 0, 1 = bit 0 transferred first (both directions)

Ports:
- clk  in  1  system clock (CLK100MHZ)
- rst  in  1  synchronous, active-high reset
- sclk  in  1  SPI clock from master, asynchronous
- csel  in  1  chip select, active low, asynchronous
- mosi  in  1  master-out data, asynchronous
- miso  out  1  slave-out data
- tx_data  in  WORD_W  reply word; latched at frame start and at each word boundary
- m_data  out  WORD_W  head-of-FIFO word
- m_valid  out  1  FIFO non-empty
- m_ready  in  1  consumer pops the head when m_valid&&m_ready
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: a word was dropped because the FIFO was full
- frame_err  out  1  one-cycle pulse: csel deasserted mid-word
- clr_flags  in  1  clears `overflow` (reset also clears it)

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous, active-high.
- Reset values: miso=0, m_valid=0, m_data=0, level=0, overflow=0, frame_err=0; bit counter=0; FIFO emptied; synchronisers loaded with idle values (sclk=CPOL, csel=1, mosi=0).
- Input synchronisation:
  - sclk, csel and mosi pass through 2-flop synchronisers.
  - sclk edges are detected against a third registered copy.
  - Required sclk frequency: ≤ clk/4. Behaviour at higher rates is undefined.
- Frame FSM states: IDLE, SHIFT.
  - IDLE→SHIFT on synchronised csel 1→0: bit counter=0; tx shift register ← tx_data.
  - SHIFT→IDLE on synchronised csel 0→1.
- Sampling and shifting:
  - Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1 (leading edge = sclk leaving CPOL).
  - On each sample edge in SHIFT, the synchronised mosi shifts into rx_shift (MSB-first: into bit 0 shifting left; LSB-first: into bit WORD_W-1 shifting right), and the counter increments.
  - When the counter reaches WORD_W: the word is pushed, the counter returns to 0, and tx shift register ← tx_data. Multi-word frames are supported.
- MISO:
  - In SHIFT, miso = current first-out bit of the tx shift register.
  - The register advances on each shift edge (the edge opposite the sample edge). For CPHA=1 the first leading edge does not advance it; the first bit is presented on that edge.
  - For CPHA=0 the first bit is valid from frame start.
  - In IDLE, miso=0.
- Receive latency: a completed word is written to the FIFO on the clk after its final sample edge is detected.
  - m_valid rises the following clk, ≤4 clk after the sclk pin edge.
  - FIFO is first-word-fall-through; m_data is stable while m_valid && !m_ready.
- Full/empty boundaries:
  - Push while full with no pop → word dropped, overflow←1, FIFO contents unchanged.
  - Push and pop in the same clk while full → both occur; no overflow.
  - Pop while empty is ignored.
  - Push and pop in the same clk while empty → the pushed word is stored and m_valid=1 next clk.
  - Pointers wrap modulo DEPTH.
- Flags:
  - overflow is cleared by clr_flags or rst. If clr_flags and a new overflow coincide, overflow stays 1.
  - csel rising with counter≠0 → partial word discarded, frame_err=1 for exactly one clk, counter←0. A csel rise with counter=0 produces no pulse.
- Reset mid-frame: all state cleared. Data from the current frame is ignored until the next csel falling edge is seen after reset deasserts.

Test Plan:
- Mode 0, WORD_W=8, MSB-first: master sends 0xA5 → exactly one push; m_data=0xA5, m_valid=1 ≤4 clk after the 8th rising sclk; level=1.
- WORD_W=4, LSB_FIRST=1: bits 1,1,1,0 (msg 4'b0111) → m_data=4'h7. Same frame continued with 0x3 → second word 4'h3; level=2.
- DEPTH=4, m_ready=0: send 0x11,0x22,0x33,0x44,0x55 → level=4, overflow=1; pops return 0x11..0x44 in order; clr_flags → overflow=0.
- csel raised after 3 bits of an 8-bit word → frame_err single-cycle pulse, no push. Next full frame 0x5A received intact.
- CPOL=1, CPHA=1, tx_data=0x3C, master sends 0x00 → master captures 0x3C on MISO; m_data=0x00.
- rst asserted after 5 bits, then deasserted, then a new frame 0xC3 → only 0xC3 received, level=1, all flags 0.
